// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 codes,
// FSM state encoding and byte-lane bit offsets within a data word.
package riscv_lsu_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_ST_RD = 2'd2,
      S_ST_WR = 2'd3
   } lsu_state_t;

   localparam logic [4:0] BYTE0 = 5'd0;
   localparam logic [4:0] BYTE1 = 5'd8;
   localparam logic [4:0] BYTE2 = 5'd16;
   localparam logic [4:0] BYTE3 = 5'd24;

   function automatic logic [4:0] lane_shift(input logic [1:0] lane);
      case (lane)
         2'd0:    return BYTE0;
         2'd1:    return BYTE1;
         2'd2:    return BYTE2;
         default: return BYTE3;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/half extraction with sign/zero extension
// and sub-word store merge into a previously read memory word.
module lsu_align
   import riscv_lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]            funct3,
   input  logic [1:0]            lane,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic [DATA_WIDTH-1:0] store_word
);

   logic [4:0]            sh;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] mask;

   always_comb begin
      sh        = lane_shift(lane);
      shifted   = rdata >> sh;
      load_data = rdata;
      case (funct3)
         F3_B:    load_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
         F3_H:    load_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
         F3_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
         F3_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
         default: load_data = rdata;
      endcase

      // Only the addressed lanes take store data; the rest keep the read word.
      case (funct3[1:0])
         2'd0:    mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << sh;
         2'd1:    mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << sh;
         default: mask = '1;
      endcase
      store_word = (rdata & ~mask) | ((wdata << sh) & mask);
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one request at a time, word-aligned memory
// accesses, sub-word loads with extension and read-modify-write sub-word stores.
module load_store_unit
   import riscv_lsu_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int MEM_ADDR_BITS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  misaligned,
   output logic                  access_fault,
   output logic [31:0]           mem_addr,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   // valid/ready: a request transfers on a rising edge where req_valid and
   // req_ready are both high; req_ready is high only while the unit is idle.
   lsu_state_t            state;
   logic [1:0]            lane_q;
   logic [2:0]            funct3_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] load_data;
   logic [DATA_WIDTH-1:0] store_word;
   logic                  illegal;
   logic                  bad_align;
   logic                  out_of_range;

   assign req_ready = (state == S_IDLE);

   lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .funct3     (funct3_q),
      .lane       (lane_q),
      .rdata      (mem_rdata),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_word (store_word)
   );

   always_comb begin
      illegal      = req_write ? (req_funct3 > F3_W)
                               : !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      bad_align    = illegal
                     || ((req_funct3[1:0] == 2'd1) && req_addr[0])
                     || ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
      out_of_range = |req_addr[31:MEM_ADDR_BITS];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         lane_q       <= '0;
         funct3_q     <= '0;
         wdata_q      <= '0;
         resp_valid   <= 1'b0;
         resp_rdata   <= '0;
         misaligned   <= 1'b0;
         access_fault <= 1'b0;
         mem_addr     <= '0;
         mem_read     <= 1'b0;
         mem_write    <= 1'b0;
         mem_wdata    <= '0;
      end else begin
         resp_valid   <= 1'b0;
         misaligned   <= 1'b0;
         access_fault <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  lane_q   <= req_addr[1:0];
                  funct3_q <= req_funct3;
                  wdata_q  <= req_wdata;
                  if (bad_align) begin
                     misaligned <= 1'b1;
                  end else if (out_of_range) begin
                     access_fault <= 1'b1;
                  end else begin
                     mem_addr <= {req_addr[31:2], 2'b00};
                     if (!req_write) begin
                        state    <= S_LOAD;
                        mem_read <= 1'b1;
                     end else if (req_funct3 == F3_W) begin
                        state     <= S_ST_WR;
                        mem_write <= 1'b1;
                        mem_wdata <= req_wdata;
                     end else begin
                        state    <= S_ST_RD;
                        mem_read <= 1'b1;
                     end
                  end
               end
            end
            S_LOAD: begin
               mem_read   <= 1'b0;
               resp_rdata <= load_data;
               resp_valid <= 1'b1;
               state      <= S_IDLE;
            end
            S_ST_RD: begin
               // mem_wdata doubles as the merge buffer for the write cycle.
               mem_read  <= 1'b0;
               mem_write <= 1'b1;
               mem_wdata <= store_word;
               state     <= S_ST_WR;
            end
            S_ST_WR: begin
               mem_write  <= 1'b0;
               resp_valid <= 1'b1;
               resp_rdata <= '0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage front end of the pipelined RISC-V core. Sits between the EX/MEM pipeline register and the word-organised data memory.
- Accepts one load or store request at a time via a valid/ready handshake.
- Always presents word-aligned addresses to the memory.
- Performs byte/half extraction and sign/zero extension for loads, and read-modify-write for sub-word stores.
- Flags misaligned and out-of-range accesses.

Parameters:
- DATA_WIDTH, 32, data path and memory word width
- MEM_ADDR_BITS, 8, byte-address bits decoded by data memory (64 words); higher address bits must be zero

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present from MEM stage
- req_ready  out  1  unit can accept a request this cycle (low = stall pipeline)
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits used for SB/SH)
- resp_valid  out  1  one-cycle pulse: load data valid or store complete
- resp_rdata  out  32  extended load result; 0 for stores
- misaligned  out  1  one-cycle pulse: misaligned access or illegal funct3
- access_fault  out  1  one-cycle pulse: req_addr[31:MEM_ADDR_BITS] nonzero
- mem_addr  out  32  word-aligned address to data memory, bits [1:0] always 0
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  combinational word read data from memory

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - resp_valid, misaligned, access_fault, mem_read, mem_write = 0.
  - resp_rdata, mem_addr, mem_wdata = 0.
  - An in-flight operation is aborted with no write issued.
- States: IDLE, LOAD, ST_RD, ST_WR.
- req_ready = 1 only in IDLE. req_valid outside IDLE is ignored; the requester holds it until accepted.
- IDLE, on req_valid: latch addr, funct3, wdata and write; then check in priority order:
  1. Illegal funct3 (load 3/6/7, store >2), or half access with addr[0]=1, or word access with addr[1:0]≠0 → misaligned pulse next cycle, no memory access, stay IDLE.
  2. Out-of-range address → access_fault pulse next cycle, stay IDLE.
  3. Otherwise:
     - load → LOAD
     - SW → ST_WR with wbuf=wdata
     - SB/SH → ST_RD
- LOAD (1 cycle):
  - mem_read=1, mem_addr={addr[31:2],00}.
  - Extract the byte at lane addr[1:0] or the half at lane addr[1]; sign-extend for LB/LH, zero-extend for LBU/LHU.
  - Register the result into resp_rdata; resp_valid=1 next cycle; → IDLE.
  - Load latency: accept edge → resp_valid 2 cycles later. req_ready is high in the resp_valid cycle (back-to-back allowed).
- ST_RD (1 cycle):
  - mem_read=1.
  - wbuf = mem_rdata with the addressed byte/half replaced by wdata[7:0]/[15:0]; other lanes unchanged.
  - → ST_WR.
- ST_WR (1 cycle):
  - mem_write=1, mem_wdata=wbuf.
  - → IDLE with resp_valid pulse and resp_rdata=0.
- Store latency: SW 2 cycles, SB/SH 3 cycles.
- Never assert mem_read and mem_write in the same cycle. mem_read/mem_write are 0 in IDLE.
- resp_valid, misaligned and access_fault are mutually exclusive and each lasts exactly one cycle.

Decomposition:
- Package riscv_lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state encoding
  - byte-lane offset constants (BYTE0..BYTE3 bit positions)
- Sub-module lsu_align (combinational): load extract/extend and store lane merge, shared by LOAD and ST_RD.

Test Plan:
- Memory preloaded word0=17, word1=9, word2=25; LW 0x4 → resp_rdata=0x00000009, resp_valid exactly 2 cycles after accept, mem_addr=0x4.
- SB wdata=0xAB at 0x5 → ST_RD reads 0x9, ST_WR writes 0x0000AB09. Then LW 0x4 → 0x0000AB09, LB 0x5 → 0xFFFFFFAB, LBU 0x5 → 0x000000AB.
- SH wdata=0x8001 at 0xA, then LH 0xA → 0xFFFF8001 and LW 0x8 → 0x80010019.
- LW 0x6, LH 0x3, funct3=3 load → misaligned pulse each, mem_read/mem_write never asserted. LW 0x100 → access_fault pulse.
- Assert rst during ST_RD of an SB → outputs zero immediately, mem_write never asserted, memory word unchanged. First request after reset is accepted normally.
- Back-to-back: hold req_valid with LW 0x0 then LW 0x8 → req_ready low during LOAD. Responses 17 then 25 on consecutive resp_valid pulses 2 cycles apart.
